beam_thresh_loader: RTL
=======================

// Module: beam_thresh_loader
//
// PURPOSE
//  Threshold configuration sequencer for the dual-beam L1 beamform trigger.
//  - Holds a shadow copy of every beam threshold, written through a valid/ready port.
//  - On commit, walks the beams in order, driving thresh/thresh_ce one beam per cycle, then pulses update.
//  - The beamformer thresholds therefore change atomically.
//  - Sits between the register/AXI-lite config slave and beamform_trigger.
//
// PARAMETERS
//  NBEAMS          2          number of beams; thresh_ce_o width; must be >= 1
//  DEFAULT_THRESH  18'h00FA0  shadow value after reset; loaded automatically
//  AW              $clog2(NBEAMS)>0 ? $clog2(NBEAMS) : 1   address width (derived, localparam)
//
// PORTS
//  clk_i        in   1       system clock; single clock domain
//  rst_i        in   1       synchronous, active-high reset
//  wr_valid_i   in   1       shadow write request
//  wr_ready_o   out  1       shadow write accept
//  wr_addr_i    in   AW      beam index of write
//  wr_data_i    in   18      threshold value
//  commit_i     in   1       request to load all shadow values into the beamformer
//  busy_o       out  1       load sequence in progress
//  done_o       out  1       1-cycle pulse when the sequence completes
//  err_o        out  1       sticky: a write addressed a beam >= NBEAMS
//  thresh_o     out  18      to beamform_trigger thresh_i
//  thresh_ce_o  out  NBEAMS  to beamform_trigger thresh_ce_i (one-hot or zero)
//  update_o     out  1       to beamform_trigger update_i
//
// BEHAVIOUR
//  - Reset values (at the clock edge with rst_i=1):
//    - outputs: thresh_o=0, thresh_ce_o=0, update_o=0, done_o=0, busy_o=0, err_o=0.
//    - state: shadow[*]=DEFAULT_THRESH; state=IDLE; commit_pend=1.
//    - wr_ready_o=0 while rst_i=1.
//  - All outputs are registered except wr_ready_o, which is = (state==IDLE && !commit_pend && !rst_i).
//  - Write: a handshake occurs on any edge with wr_valid_i & wr_ready_o.
//    - addr<NBEAMS: shadow[addr]<=wr_data_i.
//    - else: data is dropped and err_o<=1 (cleared only by rst_i).
//  - FSM states:
//    - IDLE: if (commit_i | commit_pend), go to LOAD with idx=0 and clear commit_pend.
//    - LOAD: thresh_o=shadow[idx], thresh_ce_o=1<<idx; idx++. After idx==NBEAMS-1, go to UPDATE.
//    - UPDATE: thresh_ce_o=0, update_o=1 for exactly one cycle, then go to IDLE with done_o=1 for one cycle.
//  - Latency: if commit_i is sampled at edge 0, then:
//    - the beam k strobe is visible cycles 1..NBEAMS;
//    - update_o is visible in cycle NBEAMS+1;
//    - done_o is visible in cycle NBEAMS+2.
//    - busy_o is high in cycles 1..NBEAMS+1.
//  - Write and commit in the same IDLE cycle: the write is accepted and its value is included in the load.
//  - commit_i while not IDLE: sets commit_pend.
//    - A new sequence starts on the edge after done. Here done_o and beam-0 ce are in consecutive cycles.
//    - Multiple commits while busy collapse to one.
//  - Writes are never accepted while busy or while pending, so shadow values are stable during LOAD.
//  - After reset release, one full sequence runs automatically, loading DEFAULT_THRESH to all beams.
//    - Beam-0 ce appears in the cycle after the first edge with rst_i=0.
//  - rst_i mid-sequence: outputs return to reset values at that edge; the partial load is abandoned.
//    No update_o is issued; the auto-load reruns after release.
//  - NBEAMS=1: LOAD lasts one cycle; wr_addr_i is 1 bit and addr=1 sets err_o.
//
// CONFIGURATION
//  BEAM_THRESH_READBACK_EN
//  - Defined: adds input rd_addr_i[AW-1:0] and output rd_data_o[17:0].
//    - rd_data_o <= shadow[rd_addr_i], registered with 1-cycle latency.
//    - rd_data_o is 0 for addr>=NBEAMS and 0 during reset.
//    - A readback in the cycle after a write to the same address returns the new value.
//  - Undefined: both ports are absent and there is no readback logic.
//
// TESTING (NBEAMS=2 unless noted)
//  - Reset release:
//    - ce=01 with thresh=0x00FA0, then ce=10 with 0x00FA0, then update=1, then done=1.
//    - wr_ready_o=0 until the done cycle.
//  - Write beam0=0x1234 and beam1=0x3FFFF, then commit:
//    - thresh/ce = 0x1234/01, then 0x3FFFF/10, then update; done at commit+4.
//  - Write beam1=0x00555 plus commit in the same cycle: beam-1 strobe carries 0x00555.
//  - Commit twice mid-sequence:
//    - exactly one extra sequence starts right after done;
//    - a total of 2 update pulses.
//  - Write to addr 1 with NBEAMS=1: err_o=1; shadow unchanged; next load still DEFAULT_THRESH.
//  - rst_i during ce=10:
//    - no update_o;
//    - after release, the auto-load runs with DEFAULT_THRESH (prior writes lost).
//    - With BEAM_THRESH_READBACK_EN: rd_data_o returns the written value one cycle after rd_addr_i.

Source files
------------

// File: rtl/beam_thresh_loader.sv
// Shadow threshold store that loads every beam in turn and then strobes update_o, so the
// beamformer thresholds change atomically. Optional readback port: BEAM_THRESH_READBACK_EN.
module beam_thresh_loader #(
  parameter int unsigned NBEAMS         = 2,
  parameter logic [17:0] DEFAULT_THRESH = 18'h00FA0,
  localparam int unsigned AW            = (NBEAMS > 1) ? $clog2(NBEAMS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_valid_i,
  output logic              wr_ready_o,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [17:0]       wr_data_i,
  input  logic              commit_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [17:0]       thresh_o,
  output logic [NBEAMS-1:0] thresh_ce_o,
  output logic              update_o
`ifdef BEAM_THRESH_READBACK_EN
  ,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [17:0]       rd_data_o
`endif
);

  typedef enum logic [1:0] {StIdle, StLoad, StUpdate} state_e;

  state_e              r_state, w_state_d;
  logic [AW-1:0]       r_idx, w_idx_d;
  logic                r_pend, w_pend_d;
  logic [17:0]         r_shadow [NBEAMS];
  logic [17:0]         r_thresh, w_thresh_d;
  logic [NBEAMS-1:0]   r_ce, w_ce_d;
  logic                r_update, w_update_d;
  logic                r_done, w_done_d;
  logic                r_busy, w_busy_d;
  logic                r_err;
  logic                w_wr_fire;
  logic                w_addr_ok;
  logic                w_start;

  assign wr_ready_o = (r_state == StIdle) && !r_pend && !rst_i;
  assign w_wr_fire  = wr_valid_i && wr_ready_o;
  assign w_addr_ok  = 32'(wr_addr_i) < NBEAMS;
  assign w_start    = commit_i || r_pend;

  // UPDATE spans two cycles: the first raises update_o, the second raises done_o and may
  // chain straight into a pending sequence so done_o and the beam-0 strobe are adjacent.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_pend_d  = r_pend || commit_i;
    case (r_state)
      StIdle: begin
        if (w_start) begin
          w_state_d = StLoad;
          w_idx_d   = '0;
          w_pend_d  = 1'b0;
        end
      end
      StLoad: begin
        if (r_idx == AW'(NBEAMS - 1)) begin
          w_state_d = StUpdate;
          w_idx_d   = '0;
        end else begin
          w_idx_d = r_idx + 1'b1;
        end
      end
      StUpdate: begin
        if (r_update) begin
          w_idx_d = '0;
          if (w_start) begin
            w_state_d = StLoad;
            w_pend_d  = 1'b0;
          end else begin
            w_state_d = StIdle;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_thresh_d = r_thresh;
    w_ce_d     = '0;
    w_update_d = 1'b0;
    w_done_d   = 1'b0;
    w_busy_d   = 1'b0;
    case (r_state)
      StLoad: begin
        w_thresh_d = r_shadow[r_idx];
        w_ce_d     = NBEAMS'(1) << r_idx;
        w_busy_d   = 1'b1;
      end
      StUpdate: begin
        w_update_d = !r_update;
        w_busy_d   = !r_update;
        w_done_d   = r_update;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= StIdle;
      r_idx    <= '0;
      r_pend   <= 1'b1;
      r_thresh <= '0;
      r_ce     <= '0;
      r_update <= 1'b0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
      for (int unsigned i = 0; i < NBEAMS; i++) begin
        r_shadow[i] <= DEFAULT_THRESH;
      end
    end else begin
      r_state  <= w_state_d;
      r_idx    <= w_idx_d;
      r_pend   <= w_pend_d;
      r_thresh <= w_thresh_d;
      r_ce     <= w_ce_d;
      r_update <= w_update_d;
      r_done   <= w_done_d;
      r_busy   <= w_busy_d;
      if (w_wr_fire) begin
        if (w_addr_ok) begin
          r_shadow[wr_addr_i] <= wr_data_i;
        end else begin
          r_err <= 1'b1;
        end
      end
    end
  end

`ifdef BEAM_THRESH_READBACK_EN
  logic [17:0] r_rd_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= (32'(rd_addr_i) < NBEAMS) ? r_shadow[rd_addr_i] : '0;
    end
  end

  assign rd_data_o = r_rd_data;
`endif

  assign thresh_o    = r_thresh;
  assign thresh_ce_o = r_ce;
  assign update_o    = r_update;
  assign done_o      = r_done;
  assign busy_o      = r_busy;
  assign err_o       = r_err;

endmodule
